bufferidex_skid: RTL and testbench
==================================

Name: bufferidex_skid

Overview:
- Parametrised successor to the fixed 16-bit ID/EX buffer.
- Elastic ID/EX pipeline stage with a 2-entry skid buffer, ready/valid handshake on both sides, synchronous flush, and forced-NOP control on bubbles.
- Sits between decode and execute.
- Decode can stall execute, and execute can stall decode, without combinational ready paths.

Parameters:
- DATA_W, 16, width of every data/register channel (D1, D2, D15, RS, RT1, RT2, RD)
- CTRL_W, 4, width of control word
- NOP_CTRL, 0, control value driven on OC when output not valid

Ports:
- C  input  1  clock, rising edge
- R  input  1  reset, asynchronous, active-low
- in_valid  input  1  decode presents valid bundle
- in_ready  output  1  stage can accept bundle this cycle
- ID1, ID2, ID15, IRS, IRT1, IRT2, IRD  input  DATA_W each  incoming data bundle
- IC  input  CTRL_W  incoming control
- flush  input  1  synchronous kill of all held entries
- out_valid  output  1  OD*/OC hold valid bundle
- out_ready  input  1  execute accepts bundle this cycle
- OD1, OD2, OD15, ORS, ORT1, ORT2, ORD  output  DATA_W each  outgoing data bundle
- OC  output  CTRL_W  outgoing control (NOP_CTRL when out_valid=0)

Behaviour:
- Clock and reset: one clock C; R asynchronous, active-low.
- Storage: main entry (drives outputs) and skid entry, each holding a full bundle plus a valid bit.
- State is encoded by the valid bits:
  - EMPTY: main=0, skid=0
  - ONE: main=1, skid=0
  - FULL: main=1, skid=1
- Reset (R=0, immediate): state EMPTY.
  - All OD*/OR* = 0, OC = NOP_CTRL, out_valid = 0, in_ready = 1.
  - Reset mid-transfer discards all held bundles.
- in_ready = ~skid_valid. It is a pure register output, with no combinational path from out_ready.
- out_valid = main_valid. OC = main_valid ? main_ctrl : NOP_CTRL.
- Transfer rules: accept = in_valid & in_ready; take = out_valid & out_ready.
- EMPTY:
  - accept → main ← input, ONE. Latency in→out is 1 cycle.
- ONE:
  - accept & take → main ← input, stay ONE.
  - accept & ~take → skid ← input, FULL.
  - ~accept & take → EMPTY.
  - else hold.
- FULL (in_ready=0):
  - take → main ← skid, skid cleared, ONE.
  - else hold. Outputs stay stable while out_valid & ~out_ready.
- Flush (sampled at rising edge):
  - Clears main_valid and skid_valid → EMPTY next cycle.
  - Overrides a simultaneous accept (incoming bundle dropped) and a simultaneous take (execute must treat the take as completed in that same cycle).
  - Data registers need not clear on flush; OC shows NOP_CTRL because out_valid=0.
- Ordering: bundles leave in arrival order; none duplicated, none lost except by flush or reset.
- Throughput: 1 bundle/cycle when out_ready held high.
- Width: all data paths are copied verbatim; no arithmetic.

Optional Feature:
- Macro: BUFFERIDEX_STALLCNT_EN.
- When defined, adds output stall_cnt [15:0].
  - Increments each cycle where out_valid=1 & out_ready=0.
  - Saturates at 16'hFFFF.
  - Cleared by R=0 only; flush does not clear it.
- When not defined, the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Reset release: R=0 → all outputs 0, OC=NOP_CTRL=0, out_valid=0, in_ready=1. Then R=1, in_valid=1, IC=4'h8, ID1=16'h0A01, out_ready=1 → next cycle out_valid=1, OC=4'h8, OD1=16'h0A01.
- Streaming: 4 bundles ID15=16'hFFF0, 16'h000F, 16'h1234, 16'hABCD on consecutive cycles, out_ready=1 → OD15 shows the same sequence one cycle later, in_ready stays 1 throughout.
- Backpressure: out_ready=0, push IRS=16'hE00F then IRS=16'h0056 → in_ready=0 after the second push, ORS holds 16'hE00F. Raise out_ready → ORS=16'hE00F, then 16'h0056 next cycle; in_ready returns to 1.
- Flush in FULL with in_valid=1 carrying IRD=16'h200F → next cycle out_valid=0, OC=0, in_ready=1. 16'h200F never appears at ORD with out_valid=1.
- Async reset mid-stall: in FULL state assert R=0 between clock edges → outputs zero immediately, without waiting for a clock edge. After release, EMPTY.
- BUFFERIDEX_STALLCNT_EN defined: hold out_ready=0 for 5 cycles with out_valid=1 → stall_cnt=5; flush leaves it at 5; R=0 → 0.

Source files
------------

// File: rtl/bufferidex_skid.sv
// Elastic ID/EX pipeline stage: main + skid entry, registered ready, sync flush, NOP on bubbles.
// Optional BUFFERIDEX_STALLCNT_EN adds a saturating stall_cnt output.
module bufferidex_skid #(
  parameter int unsigned        DATA_W   = 16,
  parameter int unsigned        CTRL_W   = 4,
  parameter logic [CTRL_W-1:0]  NOP_CTRL = '0
) (
  input  logic              C,
  input  logic              R,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] ID1,
  input  logic [DATA_W-1:0] ID2,
  input  logic [DATA_W-1:0] ID15,
  input  logic [DATA_W-1:0] IRS,
  input  logic [DATA_W-1:0] IRT1,
  input  logic [DATA_W-1:0] IRT2,
  input  logic [DATA_W-1:0] IRD,
  input  logic [CTRL_W-1:0] IC,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] OD1,
  output logic [DATA_W-1:0] OD2,
  output logic [DATA_W-1:0] OD15,
  output logic [DATA_W-1:0] ORS,
  output logic [DATA_W-1:0] ORT1,
  output logic [DATA_W-1:0] ORT2,
  output logic [DATA_W-1:0] ORD,
  output logic [CTRL_W-1:0] OC
`ifdef BUFFERIDEX_STALLCNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int unsigned BundleW = 7 * DATA_W + CTRL_W;

  // Encoding is {main_valid, skid_valid}.
  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StOne   = 2'b10,
    StFull  = 2'b11
  } state_e;

  state_e               state_q, state_d;
  logic [BundleW-1:0]   in_bundle;
  logic [BundleW-1:0]   main_q, main_d;
  logic [BundleW-1:0]   skid_q, skid_d;
  logic [CTRL_W-1:0]    main_ctrl;
  logic                 accept, take;

  assign in_bundle = {ID1, ID2, ID15, IRS, IRT1, IRT2, IRD, IC};
  assign {OD1, OD2, OD15, ORS, ORT1, ORT2, ORD, main_ctrl} = main_q;

  assign in_ready  = (state_q != StFull);
  assign out_valid = (state_q != StEmpty);
  assign OC        = out_valid ? main_ctrl : NOP_CTRL;

  assign accept = in_valid & in_ready;
  assign take   = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            main_d  = in_bundle;
            state_d = StOne;
          end
        end
        StOne: begin
          if (accept && take) begin
            main_d = in_bundle;
          end else if (accept) begin
            skid_d  = in_bundle;
            state_d = StFull;
          end else if (take) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (take) begin
            main_d  = skid_q;
            state_d = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef BUFFERIDEX_STALLCNT_EN
  logic [15:0] stall_cnt_q;

  // Counts across flushes; only reset clears it.
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      stall_cnt_q <= '0;
    end else if (out_valid && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_bufferidex_skid.sv
// Scoreboard bench for bufferidex_skid: a depth-2 queue model predicts handshakes and output order.
module tb_bufferidex_skid;

  localparam int BW = 7 * 16 + 4;
  typedef logic [BW-1:0] bundle_t;

  logic        C = 1'b0;
  logic        R;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [15:0] ID1, ID2, ID15, IRS, IRT1, IRT2, IRD;
  logic [15:0] OD1, OD2, OD15, ORS, ORT1, ORT2, ORD;
  logic [3:0]  IC, OC;
`ifdef BUFFERIDEX_STALLCNT_EN
  logic [15:0] stall_cnt;
`endif

  bundle_t in_b, obs_b;
  bundle_t q[$];
  int      n_tests = 0;
  int      n_fail  = 0;
  bit      m_take, m_acc;

  assign in_b  = {ID1, ID2, ID15, IRS, IRT1, IRT2, IRD, IC};
  assign obs_b = {OD1, OD2, OD15, ORS, ORT1, ORT2, ORD, OC};

  bufferidex_skid dut (
    .C        (C),
    .R        (R),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ID1      (ID1),
    .ID2      (ID2),
    .ID15     (ID15),
    .IRS      (IRS),
    .IRT1     (IRT1),
    .IRT2     (IRT2),
    .IRD      (IRD),
    .IC       (IC),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .OD1      (OD1),
    .OD2      (OD2),
    .OD15     (OD15),
    .ORS      (ORS),
    .ORT1     (ORT1),
    .ORT2     (ORT2),
    .ORD      (ORD),
    .OC       (OC)
`ifdef BUFFERIDEX_STALLCNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 C = ~C;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge C);
    #1;
  endtask

  task automatic set_rand();
    ID1  = 16'($urandom);
    ID2  = 16'($urandom);
    ID15 = 16'($urandom);
    IRS  = 16'($urandom);
    IRT1 = 16'($urandom);
    IRT2 = 16'($urandom);
    IRD  = 16'($urandom);
    IC   = 4'($urandom);
  endtask

  // Reference model: bounded FIFO of two bundles, no knowledge of main/skid split.
  always @(posedge C) begin
    if (R) begin
      m_take = (q.size() != 0) && out_ready;
      m_acc  = in_valid && (q.size() < 2);
      if (flush) begin
        q.delete();
      end else begin
        if (m_take) void'(q.pop_front());
        if (m_acc) q.push_back(in_b);
      end
    end
  end

  always @(negedge C) begin
    if (R) begin
      check("out_valid", {127'd0, out_valid}, {127'd0, q.size() != 0});
      check("in_ready", {127'd0, in_ready}, {127'd0, q.size() < 2});
      if (q.size() != 0) check("bundle", obs_b, q[0]);
      else check("oc_nop", {124'd0, OC}, 128'd0);
    end
  end

  initial begin
    logic [15:0] s_vals [4];
    s_vals = '{16'hFFF0, 16'h000F, 16'h1234, 16'hABCD};
    R = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    ID1 = '0; ID2 = '0; ID15 = '0; IRS = '0; IRT1 = '0; IRT2 = '0; IRD = '0; IC = '0;

    // Reset state
    #3;
    check("rst_outputs", obs_b, 128'd0);
    check("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check("rst_in_ready", {127'd0, in_ready}, 128'd1);
    #9 R = 1'b1;

    // First transfer, one-cycle latency
    set_rand(); IC = 4'h8; ID1 = 16'h0A01; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    #3;
    check("first_valid", {127'd0, out_valid}, 128'd1);
    check("first_oc", {124'd0, OC}, 128'h8);
    check("first_od1", {112'd0, OD1}, 128'h0A01);
    step();

    // Streaming at full rate
    for (int i = 0; i < 4; i++) begin
      set_rand(); ID15 = s_vals[i]; in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    step(); step();

    // Backpressure fills skid entry
    out_ready = 1'b0;
    set_rand(); IRS = 16'hE00F; in_valid = 1'b1;
    step();
    set_rand(); IRS = 16'h0056;
    step();
    in_valid = 1'b0;
    #3;
    check("bp_in_ready", {127'd0, in_ready}, 128'd0);
    check("bp_hold_rs", {112'd0, ORS}, 128'hE00F);
    step();
    out_ready = 1'b1;
    #3;
    check("bp_drain_rs0", {112'd0, ORS}, 128'hE00F);
    step();
    #3;
    check("bp_drain_rs1", {112'd0, ORS}, 128'h0056);
    check("bp_ready_back", {127'd0, in_ready}, 128'd1);
    step(); step();

    // Flush while full, with a competing input
    out_ready = 1'b0;
    set_rand(); in_valid = 1'b1;
    step();
    set_rand();
    step();
    set_rand(); IRD = 16'h200F; flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    #3;
    check("flush_valid", {127'd0, out_valid}, 128'd0);
    check("flush_oc", {124'd0, OC}, 128'd0);
    check("flush_ready", {127'd0, in_ready}, 128'd1);
    out_ready = 1'b1;
    step(); step();

    // Randomised traffic
    repeat (300) begin
      set_rand();
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 19) == 0);
      step();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    step(); step(); step();

    // Asynchronous reset while stalled in FULL
    out_ready = 1'b0;
    set_rand(); in_valid = 1'b1;
    step();
    set_rand();
    step();
    in_valid = 1'b0;
    #2;
    R = 1'b0;
    q.delete();
    #1;
    check("arst_outputs", obs_b, 128'd0);
    check("arst_valid", {127'd0, out_valid}, 128'd0);
    check("arst_ready", {127'd0, in_ready}, 128'd1);
    step();
    #2 R = 1'b1;
    step();
    #3;
    check("post_arst_valid", {127'd0, out_valid}, 128'd0);
    check("post_arst_ready", {127'd0, in_ready}, 128'd1);

`ifdef BUFFERIDEX_STALLCNT_EN
    // Stall counter: five stalled cycles, flush keeps it, reset clears it
    step();
    set_rand(); in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    #3;
    check("stall_cnt_5", {112'd0, stall_cnt}, 128'd5);
    out_ready = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0;
    #3;
    check("stall_cnt_flush", {112'd0, stall_cnt}, 128'd5);
    R = 1'b0;
    q.delete();
    #1;
    check("stall_cnt_rst", {112'd0, stall_cnt}, 128'd0);
    #2 R = 1'b1;
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
